// File: rtl/axi_lite_arb2.sv
// axi_lite_arb2: two-master AXI-Lite arbiter in front of a single slave.
// The write path (AW/W/B) and the read path (AR/R) each have their own
// round-robin arbiter. A grant is held for one complete transaction.
// Forward paths are pure muxes, so they add no latency.
//
// Handshake rule on every channel: a transfer happens in the cycle where
// VALID and READY are both high at the rising edge of ACLK. A master that is
// not granted sees READY = 0 and VALID = 0 on every channel, and its
// RDATA/BRESP/RRESP are driven to 0.
module axi_lite_arb2 #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                ACLK,
   input  logic                ARESET,
   // master-side write address / data / response
   input  logic [2*ADDR_W-1:0] M_AWADDR,
   input  logic [1:0]          M_AWVALID,
   output logic [1:0]          M_AWREADY,
   input  logic [2*DATA_W-1:0] M_WDATA,
   input  logic [1:0]          M_WVALID,
   output logic [1:0]          M_WREADY,
   output logic [3:0]          M_BRESP,
   output logic [1:0]          M_BVALID,
   input  logic [1:0]          M_BREADY,
   // master-side read address / data
   input  logic [2*ADDR_W-1:0] M_ARADDR,
   input  logic [1:0]          M_ARVALID,
   output logic [1:0]          M_ARREADY,
   output logic [2*DATA_W-1:0] M_RDATA,
   output logic [3:0]          M_RRESP,
   output logic [1:0]          M_RVALID,
   input  logic [1:0]          M_RREADY,
   // slave-side write
   output logic [ADDR_W-1:0]   S_AWADDR,
   output logic                S_AWVALID,
   input  logic                S_AWREADY,
   output logic [DATA_W-1:0]   S_WDATA,
   output logic                S_WVALID,
   input  logic                S_WREADY,
   input  logic [1:0]          S_BRESP,
   input  logic                S_BVALID,
   output logic                S_BREADY,
   // slave-side read
   output logic [ADDR_W-1:0]   S_ARADDR,
   output logic                S_ARVALID,
   input  logic                S_ARREADY,
   input  logic [DATA_W-1:0]   S_RDATA,
   input  logic [1:0]          S_RRESP,
   input  logic                S_RVALID,
   output logic                S_RREADY,
   // grants and FSM state for observation
   output logic [1:0]          W_GNT,
   output logic [1:0]          R_GNT,
   output logic [1:0]          w_state_dbg,
   output logic [1:0]          r_state_dbg
);

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_XFER = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_ADDR = 2'd1,
      R_DATA = 2'd2
   } r_state_t;

   w_state_t w_state, w_state_nxt;
   r_state_t r_state, r_state_nxt;

   // w_sel/r_sel: index of the master that owns the path.
   // w_last/r_last: the most recent winner. They reset to 1 so that M0 wins
   // the first tie.
   logic w_sel, w_sel_nxt, w_last, w_last_nxt;
   logic r_sel, r_sel_nxt, r_last, r_last_nxt;
   logic aw_done, aw_done_nxt, w_done, w_done_nxt;
   logic w_pick, r_pick;
   logic aw_hs, w_hs;

   // Round-robin pick: on a tie the master that did not win last time gets
   // the grant. Otherwise the only requester wins.
   always_comb begin
      w_pick = (&M_AWVALID) ? ~w_last : M_AWVALID[1];
      r_pick = (&M_ARVALID) ? ~r_last : M_ARVALID[1];
   end

   // Write-path state register, grant owner and sticky AW/W completion flags.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         w_state <= W_IDLE;
         w_sel   <= 1'b0;
         w_last  <= 1'b1;
         aw_done <= 1'b0;
         w_done  <= 1'b0;
      end else begin
         w_state <= w_state_nxt;
         w_sel   <= w_sel_nxt;
         w_last  <= w_last_nxt;
         aw_done <= aw_done_nxt;
         w_done  <= w_done_nxt;
      end
   end

   // Write-path next state and channel routing. Each channel is gated off
   // toward the slave once its handshake has completed.
   always_comb begin
      w_state_nxt = w_state;
      w_sel_nxt   = w_sel;
      w_last_nxt  = w_last;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      aw_hs       = 1'b0;
      w_hs        = 1'b0;
      M_AWREADY   = 2'b00;
      M_WREADY    = 2'b00;
      M_BVALID    = 2'b00;
      M_BRESP     = 4'b0000;
      S_AWADDR    = '0;
      S_AWVALID   = 1'b0;
      S_WDATA     = '0;
      S_WVALID    = 1'b0;
      S_BREADY    = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (|M_AWVALID) begin
               w_sel_nxt   = w_pick;
               w_last_nxt  = w_pick;
               w_state_nxt = W_XFER;
            end
         end
         W_XFER: begin
            S_AWADDR  = w_sel ? M_AWADDR[2*ADDR_W-1:ADDR_W] : M_AWADDR[ADDR_W-1:0];
            S_WDATA   = w_sel ? M_WDATA[2*DATA_W-1:DATA_W] : M_WDATA[DATA_W-1:0];
            S_AWVALID = M_AWVALID[w_sel] & ~aw_done;
            S_WVALID  = M_WVALID[w_sel] & ~w_done;
            M_AWREADY[w_sel] = S_AWREADY & ~aw_done;
            M_WREADY[w_sel]  = S_WREADY & ~w_done;
            aw_hs       = S_AWVALID & S_AWREADY;
            w_hs        = S_WVALID & S_WREADY;
            aw_done_nxt = aw_done | aw_hs;
            w_done_nxt  = w_done | w_hs;
            if (aw_done_nxt && w_done_nxt) begin
               w_state_nxt = W_RESP;
            end
         end
         W_RESP: begin
            M_BVALID[w_sel] = S_BVALID;
            if (w_sel) begin
               M_BRESP[3:2] = S_BRESP;
            end else begin
               M_BRESP[1:0] = S_BRESP;
            end
            S_BREADY = M_BREADY[w_sel];
            if (S_BVALID && M_BREADY[w_sel]) begin
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
               w_state_nxt = W_IDLE;
            end
         end
         default: begin
            w_state_nxt = W_IDLE;
         end
      endcase
   end

   // Read-path state register and grant owner.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         r_state <= R_IDLE;
         r_sel   <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= r_state_nxt;
         r_sel   <= r_sel_nxt;
         r_last  <= r_last_nxt;
      end
   end

   // Read-path next state and channel routing.
   always_comb begin
      r_state_nxt = r_state;
      r_sel_nxt   = r_sel;
      r_last_nxt  = r_last;
      M_ARREADY   = 2'b00;
      M_RVALID    = 2'b00;
      M_RDATA     = '0;
      M_RRESP     = 4'b0000;
      S_ARADDR    = '0;
      S_ARVALID   = 1'b0;
      S_RREADY    = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (|M_ARVALID) begin
               r_sel_nxt   = r_pick;
               r_last_nxt  = r_pick;
               r_state_nxt = R_ADDR;
            end
         end
         R_ADDR: begin
            S_ARADDR  = r_sel ? M_ARADDR[2*ADDR_W-1:ADDR_W] : M_ARADDR[ADDR_W-1:0];
            S_ARVALID = M_ARVALID[r_sel];
            M_ARREADY[r_sel] = S_ARREADY;
            if (S_ARVALID && S_ARREADY) begin
               r_state_nxt = R_DATA;
            end
         end
         R_DATA: begin
            M_RVALID[r_sel] = S_RVALID;
            if (r_sel) begin
               M_RDATA[2*DATA_W-1:DATA_W] = S_RDATA;
               M_RRESP[3:2]               = S_RRESP;
            end else begin
               M_RDATA[DATA_W-1:0] = S_RDATA;
               M_RRESP[1:0]        = S_RRESP;
            end
            S_RREADY = M_RREADY[r_sel];
            if (S_RVALID && M_RREADY[r_sel]) begin
               r_state_nxt = R_IDLE;
            end
         end
         default: begin
            r_state_nxt = R_IDLE;
         end
      endcase
   end

   // Grant outputs are one-hot while a path is busy and 0 when it is idle.
   always_comb begin
      W_GNT = (w_state == W_IDLE) ? 2'b00 : (w_sel ? 2'b10 : 2'b01);
      R_GNT = (r_state == R_IDLE) ? 2'b00 : (r_sel ? 2'b10 : 2'b01);
   end

   assign w_state_dbg = w_state;
   assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axi_lite_arb2.sv
// Directed bench for axi_lite_arb2. Inputs change 1 ns after the rising
// edge, and outputs are sampled on the falling edge.
module tb_axi_lite_arb2;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;

   logic                ACLK = 1'b0;
   logic                ARESET;
   logic [2*ADDR_W-1:0] M_AWADDR;
   logic [1:0]          M_AWVALID;
   logic [1:0]          M_AWREADY;
   logic [2*DATA_W-1:0] M_WDATA;
   logic [1:0]          M_WVALID;
   logic [1:0]          M_WREADY;
   logic [3:0]          M_BRESP;
   logic [1:0]          M_BVALID;
   logic [1:0]          M_BREADY;
   logic [2*ADDR_W-1:0] M_ARADDR;
   logic [1:0]          M_ARVALID;
   logic [1:0]          M_ARREADY;
   logic [2*DATA_W-1:0] M_RDATA;
   logic [3:0]          M_RRESP;
   logic [1:0]          M_RVALID;
   logic [1:0]          M_RREADY;
   logic [ADDR_W-1:0]   S_AWADDR;
   logic                S_AWVALID;
   logic                S_AWREADY;
   logic [DATA_W-1:0]   S_WDATA;
   logic                S_WVALID;
   logic                S_WREADY;
   logic [1:0]          S_BRESP;
   logic                S_BVALID;
   logic                S_BREADY;
   logic [ADDR_W-1:0]   S_ARADDR;
   logic                S_ARVALID;
   logic                S_ARREADY;
   logic [DATA_W-1:0]   S_RDATA;
   logic [1:0]          S_RRESP;
   logic                S_RVALID;
   logic                S_RREADY;
   logic [1:0]          W_GNT;
   logic [1:0]          R_GNT;
   logic [1:0]          w_state_dbg;
   logic [1:0]          r_state_dbg;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int aw_cnt   = 0;
   int w_cnt    = 0;
   int b_cnt    = 0;
   int r_cnt    = 0;
   int aw_cyc   = 0;
   int w_cyc    = 0;
   int aw0, w0, b0, r0;

   axi_lite_arb2 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
      .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
      .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
      .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
      .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
      .W_GNT(W_GNT), .R_GNT(R_GNT),
      .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
   );

   // clock / reset block
   always #5 ACLK = ~ACLK;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // slave-side handshake monitor
   always @(posedge ACLK) begin
      cyc <= cyc + 1;
      if (!ARESET) begin
         if (S_AWVALID && S_AWREADY) begin aw_cnt <= aw_cnt + 1; aw_cyc <= cyc; end
         if (S_WVALID && S_WREADY)   begin w_cnt  <= w_cnt + 1;  w_cyc  <= cyc; end
         if (S_BVALID && S_BREADY)   b_cnt <= b_cnt + 1;
         if (S_RVALID && S_RREADY)   r_cnt <= r_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge ACLK);
      #1;
   endtask

   task automatic mid();
      @(negedge ACLK);
   endtask

   task automatic idle_inputs();
      M_AWADDR = '0; M_AWVALID = '0; M_WDATA = '0; M_WVALID = '0; M_BREADY = '0;
      M_ARADDR = '0; M_ARVALID = '0; M_RREADY = '0;
      S_AWREADY = 0; S_WREADY = 0; S_BRESP = '0; S_BVALID = 0;
      S_ARREADY = 0; S_RDATA = '0; S_RRESP = '0; S_RVALID = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_wgnt"}, 64'(W_GNT), 64'd0);
      check({tag, "_rgnt"}, 64'(R_GNT), 64'd0);
      check({tag, "_mctl"}, 64'({M_AWREADY, M_WREADY, M_BVALID, M_ARREADY, M_RVALID}), 64'd0);
      check({tag, "_mresp"}, 64'({M_BRESP, M_RRESP}), 64'd0);
      check({tag, "_mrdata"}, M_RDATA, 64'd0);
      check({tag, "_sctl"}, 64'({S_AWVALID, S_WVALID, S_BREADY, S_ARVALID, S_RREADY}), 64'd0);
      check({tag, "_sdata"}, 64'({S_AWADDR, S_WDATA, S_ARADDR}), 64'd0);
   endtask

   task automatic do_reset();
      ARESET = 1'b1;
      idle_inputs();
      next_cycle();
      next_cycle();
   endtask

   initial begin
      // ---------------- reset state ----------------
      #1;
      do_reset();
      mid();
      check_all_zero("rst");
      check("rst_state", 64'({w_state_dbg, r_state_dbg}), 64'd0);
      next_cycle();
      ARESET = 1'b0;
      mid();
      check_all_zero("rst_rel");
      next_cycle();

      // ---------------- single write from M0 ----------------
      M_AWVALID = 2'b01; M_AWADDR = {10'h0, 10'h005};
      M_WVALID  = 2'b01; M_WDATA  = {32'h0, 32'hDEADBEEF};
      S_AWREADY = 1; S_WREADY = 1;
      mid();
      check("w1_gnt_n", 64'(W_GNT), 64'd0);
      check("w1_savalid_n", 64'(S_AWVALID), 64'd0);
      next_cycle();
      mid();
      check("w1_gnt_n1", 64'(W_GNT), 64'h1);
      check("w1_awaddr", 64'(S_AWADDR), 64'h005);
      check("w1_wdata", 64'(S_WDATA), 64'hDEADBEEF);
      check("w1_svalid", 64'({S_AWVALID, S_WVALID}), 64'h3);
      check("w1_mready", 64'({M_AWREADY, M_WREADY}), 64'b0101);
      check("w1_state", 64'(w_state_dbg), 64'd1);
      next_cycle();
      M_AWVALID = 0; M_WVALID = 0; S_AWREADY = 0; S_WREADY = 0;
      S_BVALID = 1; S_BRESP = 2'b00; M_BREADY = 2'b01;
      mid();
      check("w1_bvalid", 64'(M_BVALID), 64'h1);
      check("w1_bresp", 64'(M_BRESP), 64'h0);
      check("w1_bready", 64'(S_BREADY), 64'h1);
      check("w1_gnt_n2", 64'(W_GNT), 64'h1);
      next_cycle();
      S_BVALID = 0; M_BREADY = 0;
      mid();
      check("w1_gnt_n3", 64'(W_GNT), 64'h0);
      next_cycle();

      // ---------------- simultaneous writes, round robin ----------------
      do_reset();
      ARESET = 1'b0;
      M_AWVALID = 2'b11; M_AWADDR = {10'h2AB, 10'h100};
      M_WVALID  = 2'b11; M_WDATA  = {32'hBBBB0001, 32'hAAAA0000};
      S_AWREADY = 1; S_WREADY = 1; S_BVALID = 1; S_BRESP = 2'b01; M_BREADY = 2'b11;
      mid();
      check("rr_gnt_idle0", 64'(W_GNT), 64'h0);
      next_cycle();
      for (int t = 0; t < 6; t++) begin
         mid();
         check($sformatf("rr_gnt_xfer%0d", t), 64'(W_GNT), (t % 2 == 0) ? 64'h1 : 64'h2);
         check($sformatf("rr_awaddr%0d", t), 64'(S_AWADDR), (t % 2 == 0) ? 64'h100 : 64'h2AB);
         check($sformatf("rr_wdata%0d", t), 64'(S_WDATA), (t % 2 == 0) ? 64'hAAAA0000 : 64'hBBBB0001);
         check($sformatf("rr_bvalid_xfer%0d", t), 64'(M_BVALID), 64'h0);
         next_cycle();
         if (t == 5) begin
            M_AWVALID = 2'b00; M_WVALID = 2'b00;
         end
         mid();
         check($sformatf("rr_gnt_resp%0d", t), 64'(W_GNT), (t % 2 == 0) ? 64'h1 : 64'h2);
         check($sformatf("rr_bresp%0d", t), 64'({M_BVALID, M_BRESP}),
               (t % 2 == 0) ? 64'b010001 : 64'b100100);
         next_cycle();
         mid();
         check($sformatf("rr_gnt_idle%0d", t), 64'(W_GNT), 64'h0);
         next_cycle();
      end
      idle_inputs();
      next_cycle();

      // ---------------- W before AW from M1 ----------------
      aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
      M_WVALID = 2'b10; M_WDATA = {32'hCAFEF00D, 32'h0};
      S_WREADY = 1; S_AWREADY = 0;
      for (int i = 0; i < 3; i++) begin
         mid();
         check($sformatf("wfirst_wait%0d", i), 64'({W_GNT, M_WREADY, S_WVALID}), 64'h0);
         next_cycle();
      end
      M_AWVALID = 2'b10; M_AWADDR = {10'h3C0, 10'h0};
      mid();
      check("wfirst_gnt_c3", 64'(W_GNT), 64'h0);
      next_cycle();
      mid();
      check("wfirst_gnt_c4", 64'(W_GNT), 64'h2);
      check("wfirst_wdata", 64'(S_WDATA), 64'hCAFEF00D);
      check("wfirst_awaddr", 64'(S_AWADDR), 64'h3C0);
      check("wfirst_ready_c4", 64'({M_AWREADY, M_WREADY}), 64'b0010);
      check("wfirst_svalid_c4", 64'({S_AWVALID, S_WVALID}), 64'b11);
      next_cycle();
      M_WVALID = 2'b00;
      mid();
      check("wfirst_svalid_c5", 64'({S_AWVALID, S_WVALID}), 64'b10);
      check("wfirst_gnt_c5", 64'(W_GNT), 64'h2);
      next_cycle();
      S_AWREADY = 1;
      mid();
      check("wfirst_awready_c6", 64'(M_AWREADY), 64'h2);
      next_cycle();
      M_AWVALID = 2'b00; S_AWREADY = 0; S_WREADY = 0;
      S_BVALID = 1; S_BRESP = 2'b10; M_BREADY = 2'b10;
      mid();
      check("wfirst_b", 64'({M_BVALID, M_BRESP, S_BREADY}), 64'b10_1000_1);
      next_cycle();
      S_BVALID = 0; S_BRESP = 0; M_BREADY = 0;
      mid();
      check("wfirst_gnt_end", 64'(W_GNT), 64'h0);
      check("wfirst_aw_cnt", 64'(aw_cnt - aw0), 64'd1);
      check("wfirst_w_cnt", 64'(w_cnt - w0), 64'd1);
      check("wfirst_b_cnt", 64'(b_cnt - b0), 64'd1);
      check("wfirst_order", 64'(w_cyc < aw_cyc), 64'd1);
      next_cycle();

      // ---------------- concurrent write M0 and read M1 ----------------
      M_AWVALID = 2'b01; M_AWADDR = {10'h0, 10'h010};
      M_WVALID  = 2'b01; M_WDATA  = {32'h0, 32'h11112222};
      M_ARVALID = 2'b10; M_ARADDR = {10'h020, 10'h0};
      S_AWREADY = 1; S_WREADY = 1; S_ARREADY = 1;
      mid();
      check("conc_gnt_n", 64'({W_GNT, R_GNT}), 64'h0);
      next_cycle();
      mid();
      check("conc_gnt_n1", 64'({W_GNT, R_GNT}), 64'b0110);
      check("conc_araddr", 64'({S_ARVALID, S_ARADDR}), {53'd0, 1'b1, 10'h020});
      check("conc_arready", 64'(M_ARREADY), 64'h2);
      check("conc_awaddr", 64'(S_AWADDR), 64'h010);
      check("conc_wdata", 64'(S_WDATA), 64'h11112222);
      next_cycle();
      idle_inputs();
      S_RVALID = 1; S_RDATA = 32'h12345678; S_RRESP = 2'b11; M_RREADY = 2'b10;
      S_BVALID = 1; M_BREADY = 2'b01;
      mid();
      check("conc_rvalid", 64'(M_RVALID), 64'h2);
      check("conc_rdata", M_RDATA, {32'h12345678, 32'h0});
      check("conc_rresp", 64'(M_RRESP), 64'b1100);
      check("conc_bvalid", 64'(M_BVALID), 64'h1);
      next_cycle();
      idle_inputs();
      mid();
      check("conc_gnt_end", 64'({W_GNT, R_GNT}), 64'h0);
      next_cycle();

      // ---------------- read stall from M0 ----------------
      r0 = r_cnt;
      M_ARVALID = 2'b01; M_ARADDR = {10'h0, 10'h0AA}; S_ARREADY = 1;
      next_cycle();
      mid();
      check("rst_ar_gnt", 64'(R_GNT), 64'h1);
      check("rst_ar_addr", 64'({S_ARVALID, S_ARADDR}), {53'd0, 1'b1, 10'h0AA});
      next_cycle();
      M_ARVALID = 0; S_ARREADY = 0;
      for (int i = 0; i < 5; i++) begin
         mid();
         check($sformatf("rstall_wait%0d", i), 64'({R_GNT, M_RVALID}), 64'b0100);
         next_cycle();
      end
      S_RVALID = 1; S_RDATA = 32'hA5A55A5A;
      for (int i = 0; i < 2; i++) begin
         mid();
         check($sformatf("rstall_rdy%0d", i), 64'({R_GNT, M_RVALID, S_RREADY}), 64'b01_01_0);
         next_cycle();
      end
      M_RREADY = 2'b01;
      mid();
      check("rstall_rdata", M_RDATA, {32'h0, 32'hA5A55A5A});
      check("rstall_rready", 64'(S_RREADY), 64'h1);
      next_cycle();
      S_RVALID = 0; S_RDATA = 0; M_RREADY = 0;
      mid();
      check("rstall_gnt_end", 64'(R_GNT), 64'h0);
      check("rstall_r_cnt", 64'(r_cnt - r0), 64'd1);
      next_cycle();

      // ---------------- reset in W_RESP ----------------
      M_AWVALID = 2'b10; M_AWADDR = {10'h155, 10'h0};
      M_WVALID = 2'b10; M_WDATA = {32'h0BADF00D, 32'h0};
      S_AWREADY = 1; S_WREADY = 1;
      next_cycle();
      mid();
      check("mrst_gnt", 64'(W_GNT), 64'h2);
      next_cycle();
      M_AWVALID = 0; M_WVALID = 0; S_AWREADY = 0; S_WREADY = 0; M_BREADY = 2'b10;
      ARESET = 1'b1;
      mid();
      check("mrst_resp_state", 64'(w_state_dbg), 64'd2);
      next_cycle();
      S_BVALID = 1; S_BRESP = 2'b11;
      mid();
      check_all_zero("mrst");
      next_cycle();
      idle_inputs();
      ARESET = 1'b0;
      M_AWVALID = 2'b11; M_WVALID = 2'b11; S_AWREADY = 1; S_WREADY = 1;
      next_cycle();
      mid();
      check("mrst_tie_gnt", 64'(W_GNT), 64'h1);
      next_cycle();
      idle_inputs();
      S_BVALID = 1; M_BREADY = 2'b01;
      next_cycle();
      idle_inputs();
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
